// File: rtl/seg_led_pkg.sv
`timescale 1ns/1ps
// Shared constants for the six-digit clock display: active-low segment
// patterns in {dp,g,f,e,d,c,b,a} order and default 50 MHz timing divisors.
package seg_led_pkg;

  typedef logic [7:0] seg_pattern_t;

  localparam logic [25:0] DEFAULT_MAX_NUM  = 26'd500_000;
  localparam logic [15:0] DEFAULT_SCAN_NUM = 16'd50_000;

  localparam seg_pattern_t SEG_0       = 8'hC0;
  localparam seg_pattern_t SEG_1       = 8'hF9;
  localparam seg_pattern_t SEG_2       = 8'hA4;
  localparam seg_pattern_t SEG_3       = 8'hB0;
  localparam seg_pattern_t SEG_4       = 8'h99;
  localparam seg_pattern_t SEG_5       = 8'h92;
  localparam seg_pattern_t SEG_6       = 8'h82;
  localparam seg_pattern_t SEG_7       = 8'hF8;
  localparam seg_pattern_t SEG_8       = 8'h80;
  localparam seg_pattern_t SEG_9       = 8'h90;
  localparam seg_pattern_t SEG_BLANK   = 8'hFF;
  localparam seg_pattern_t SEG_DP_MASK = 8'h7F;

  function automatic seg_pattern_t seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
// Multiplexes six BCD digits onto a common-anode display, one digit per
// scan step, with registered select and segment outputs.
module seg_scan_driver
  import seg_led_pkg::*;
#(
  parameter logic [15:0] SCAN_NUM = DEFAULT_SCAN_NUM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] digits,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  logic [15:0] scan_cnt;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic        dp_on;

  // Index 0 is the leftmost digit, held in the top nibble of digits.
  always_comb begin
    digit = digits[3:0];
    case (idx)
      3'd0:    digit = digits[23:20];
      3'd1:    digit = digits[19:16];
      3'd2:    digit = digits[15:12];
      3'd3:    digit = digits[11:8];
      3'd4:    digit = digits[7:4];
      default: digit = digits[3:0];
    endcase
  end

  assign dp_on = (idx == 3'd1) || (idx == 3'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_sel  <= 6'b111111;
      seg_led  <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_NUM - 16'd1) begin
        scan_cnt <= '0;
        idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
      seg_sel <= ~(6'b100000 >> idx);
      seg_led <= dp_on ? (seg_decode(digit) & SEG_DP_MASK) : seg_decode(digit);
    end
  end

endmodule

// File: rtl/seg_led_top.sv
`timescale 1ns/1ps
// Free-running HH:MM:SS clock on a 10 ms time base, shown on a six-digit
// multiplexed seven-segment display. No set or pause controls.
module seg_led_top
  import seg_led_pkg::*;
#(
  parameter logic [25:0] MAX_NUM  = DEFAULT_MAX_NUM,
  parameter logic [15:0] SCAN_NUM = DEFAULT_SCAN_NUM
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  output logic [5:0] seg_sel,
  output logic [7:0] seg_led
);

  logic [25:0] cnt;
  logic        tick;
  logic [6:0]  cs, cs_n;
  logic [3:0]  sec_t, sec_u, min_t, min_u, hr_t, hr_u;
  logic [3:0]  sec_t_n, sec_u_n, min_t_n, min_u_n, hr_t_n, hr_u_n;
  logic        sec_carry, min_carry, hr_carry;

  assign tick = (cnt == MAX_NUM - 26'd1);

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n)  cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + 26'd1;
  end

  // Carries ripple through every field within the same cycle as the tick.
  always_comb begin
    cs_n      = cs;
    sec_t_n   = sec_t;
    sec_u_n   = sec_u;
    min_t_n   = min_t;
    min_u_n   = min_u;
    hr_t_n    = hr_t;
    hr_u_n    = hr_u;
    sec_carry = 1'b0;
    min_carry = 1'b0;
    hr_carry  = 1'b0;
    if (tick) begin
      if (cs == 7'd99) begin
        cs_n      = '0;
        sec_carry = 1'b1;
      end else begin
        cs_n = cs + 7'd1;
      end
    end
    if (sec_carry) begin
      if (sec_u == 4'd9) begin
        sec_u_n = '0;
        if (sec_t == 4'd5) begin
          sec_t_n   = '0;
          min_carry = 1'b1;
        end else begin
          sec_t_n = sec_t + 4'd1;
        end
      end else begin
        sec_u_n = sec_u + 4'd1;
      end
    end
    if (min_carry) begin
      if (min_u == 4'd9) begin
        min_u_n = '0;
        if (min_t == 4'd5) begin
          min_t_n  = '0;
          hr_carry = 1'b1;
        end else begin
          min_t_n = min_t + 4'd1;
        end
      end else begin
        min_u_n = min_u + 4'd1;
      end
    end
    if (hr_carry) begin
      if (hr_t == 4'd2 && hr_u == 4'd3) begin
        hr_t_n = '0;
        hr_u_n = '0;
      end else if (hr_u == 4'd9) begin
        hr_u_n = '0;
        hr_t_n = hr_t + 4'd1;
      end else begin
        hr_u_n = hr_u + 4'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      cs    <= '0;
      sec_t <= '0;
      sec_u <= '0;
      min_t <= '0;
      min_u <= '0;
      hr_t  <= '0;
      hr_u  <= '0;
    end else begin
      cs    <= cs_n;
      sec_t <= sec_t_n;
      sec_u <= sec_u_n;
      min_t <= min_t_n;
      min_u <= min_u_n;
      hr_t  <= hr_t_n;
      hr_u  <= hr_u_n;
    end
  end

  seg_scan_driver #(
    .SCAN_NUM (SCAN_NUM)
  ) u_scan (
    .clk     (sys_clk),
    .rst     (sys_rst_n),
    .digits  ({hr_t, hr_u, min_t, min_u, sec_t, sec_u}),
    .seg_sel (seg_sel),
    .seg_led (seg_led)
  );

endmodule

// File: tb/tb_seg_led_top.sv
`timescale 1ns/1ps
// Directed bench for seg_led_top: two instances with shortened time bases,
// one for scan/tick timing and one for carry, rollover and reset behaviour.
module tb_seg_led_top;

  logic       clk;
  logic       rst;
  logic [5:0] sel_a, sel_b;
  logic [7:0] led_a, led_b;
  int         tests_run;
  int         fail_count;
  int         cyc;

  logic [6:0] pre_cs;
  logic [3:0] pre_ht, pre_hu, pre_mt, pre_mu, pre_st, pre_su;

  seg_led_top #(.MAX_NUM(26'd4), .SCAN_NUM(16'd3)) dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst),
    .seg_sel   (sel_a),
    .seg_led   (led_a)
  );

  seg_led_top #(.MAX_NUM(26'd2), .SCAN_NUM(16'd3)) dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst),
    .seg_sel   (sel_b),
    .seg_led   (led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic read_digit(input bit use_b, input int idx, output logic [7:0] led, output bit ok);
    logic [5:0] want;
    want = ~(6'b100000 >> idx);
    ok   = 1'b0;
    led  = 8'h00;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((use_b ? sel_b : sel_a) == want) begin
        led = use_b ? led_b : led_a;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic preload_b(input logic [3:0] ht, hu, mt, mu, st, su);
    pre_cs = 7'd0;
    pre_ht = ht;
    pre_hu = hu;
    pre_mt = mt;
    pre_mu = mu;
    pre_st = st;
    pre_su = su;
    @(negedge clk);
    force dut_b.cs    = pre_cs;
    force dut_b.hr_t  = pre_ht;
    force dut_b.hr_u  = pre_hu;
    force dut_b.min_t = pre_mt;
    force dut_b.min_u = pre_mu;
    force dut_b.sec_t = pre_st;
    force dut_b.sec_u = pre_su;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 4 && dut_b.tick; n++) @(negedge clk);
    @(posedge clk);
    #1;
    release dut_b.cs;
    release dut_b.hr_t;
    release dut_b.hr_u;
    release dut_b.min_t;
    release dut_b.min_u;
    release dut_b.sec_t;
    release dut_b.sec_u;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (sel_a !== 6'b111111) begin
      fail_count++;
      $display("[TB] FAIL reset_sel_a: got %b want %b", sel_a, 6'b111111);
    end
    tests_run++;
    if (led_a !== 8'hFF) begin
      fail_count++;
      $display("[TB] FAIL reset_led_a: got %h want %h", led_a, 8'hFF);
    end
    tests_run++;
    if (sel_b !== 6'b111111 || led_b !== 8'hFF) begin
      fail_count++;
      $display("[TB] FAIL reset_out_b: got %b/%h want 111111/ff", sel_b, led_b);
    end
    tests_run++;
    if (dut_a.cnt !== 26'd0 || dut_b.cs !== 7'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_counters: got cnt=%0d cs=%0d want 0/0", dut_a.cnt, dut_b.cs);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan;
    int         idx;
    logic [5:0] want_sel;
    logic [7:0] want_led;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      idx      = ((k - 1) / 3) % 6;
      want_sel = ~(6'b100000 >> idx);
      want_led = (idx == 1 || idx == 3) ? 8'h40 : 8'hC0;
      tests_run++;
      if (sel_a !== want_sel) begin
        fail_count++;
        $display("[TB] FAIL scan_sel cycle %0d: got %b want %b", k, sel_a, want_sel);
      end
      tests_run++;
      if (led_a !== want_led) begin
        fail_count++;
        $display("[TB] FAIL scan_led cycle %0d: got %h want %h", k, led_a, want_led);
      end
    end
  endtask

  task automatic test_tick;
    logic       want_tick;
    logic [7:0] led;
    bit         ok;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      want_tick = ((cyc % 4) == 3);
      tests_run++;
      if (dut_a.tick !== want_tick) begin
        fail_count++;
        $display("[TB] FAIL tick at cycle %0d: got %b want %b", cyc, dut_a.tick, want_tick);
      end
    end
    while (cyc < 370) @(negedge clk);
    read_digit(1'b0, 5, led, ok);
    tests_run++;
    if (!ok || led !== 8'hC0) begin
      fail_count++;
      $display("[TB] FAIL tick_sec_before: got %h (found=%0d) want c0", led, ok);
    end
    while (cyc < 420) @(negedge clk);
    read_digit(1'b0, 5, led, ok);
    tests_run++;
    if (!ok || led !== 8'hF9) begin
      fail_count++;
      $display("[TB] FAIL tick_sec_after: got %h (found=%0d) want f9", led, ok);
    end
  endtask

  task automatic test_minute_carry;
    logic [7:0] want_led [6];
    logic [7:0] led;
    bit         ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    while (cyc < 11900) @(negedge clk);
    want_led = '{8'hC0, 8'h40, 8'hC0, 8'h40, 8'h92, 8'h90};
    for (int d = 0; d < 6; d++) begin
      read_digit(1'b1, d, led, ok);
      tests_run++;
      if (!ok || led !== want_led[d]) begin
        fail_count++;
        $display("[TB] FAIL minute_before d%0d: got %h (found=%0d) want %h", d, led, ok, want_led[d]);
      end
    end
    while (cyc < 12050) @(negedge clk);
    want_led = '{8'hC0, 8'h40, 8'hC0, 8'h79, 8'hC0, 8'hC0};
    for (int d = 0; d < 6; d++) begin
      read_digit(1'b1, d, led, ok);
      tests_run++;
      if (!ok || led !== want_led[d]) begin
        fail_count++;
        $display("[TB] FAIL minute_after d%0d: got %h (found=%0d) want %h", d, led, ok, want_led[d]);
      end
    end
  endtask

  task automatic test_rollover;
    logic [7:0] want_led [6];
    logic [7:0] led;
    bit         ok;
    int         start;
    preload_b(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
    start    = cyc;
    want_led = '{8'hA4, 8'h30, 8'h92, 8'h10, 8'h92, 8'h90};
    for (int d = 0; d < 6; d++) begin
      read_digit(1'b1, d, led, ok);
      tests_run++;
      if (!ok || led !== want_led[d]) begin
        fail_count++;
        $display("[TB] FAIL rollover_before d%0d: got %h (found=%0d) want %h", d, led, ok, want_led[d]);
      end
    end
    while (cyc < start + 230) @(negedge clk);
    want_led = '{8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'hC0};
    for (int d = 0; d < 6; d++) begin
      read_digit(1'b1, d, led, ok);
      tests_run++;
      if (!ok || led !== want_led[d]) begin
        fail_count++;
        $display("[TB] FAIL rollover_after d%0d: got %h (found=%0d) want %h", d, led, ok, want_led[d]);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] want_led [6];
    logic [7:0] led;
    bit         ok;
    preload_b(4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
    want_led = '{8'hC0, 8'h40, 8'hF9, 8'h24, 8'hB0, 8'h99};
    for (int d = 0; d < 6; d++) begin
      read_digit(1'b1, d, led, ok);
      tests_run++;
      if (!ok || led !== want_led[d]) begin
        fail_count++;
        $display("[TB] FAIL midreset_before d%0d: got %h (found=%0d) want %h", d, led, ok, want_led[d]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (sel_b !== 6'b111111) begin
      fail_count++;
      $display("[TB] FAIL midreset_sel: got %b want 111111", sel_b);
    end
    tests_run++;
    if (led_b !== 8'hFF) begin
      fail_count++;
      $display("[TB] FAIL midreset_led: got %h want ff", led_b);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sel_b !== 6'b011111 || led_b !== 8'hC0) begin
      fail_count++;
      $display("[TB] FAIL midreset_first: got %b/%h want 011111/c0", sel_b, led_b);
    end
    want_led = '{8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'hC0};
    for (int d = 0; d < 6; d++) begin
      read_digit(1'b1, d, led, ok);
      tests_run++;
      if (!ok || led !== want_led[d]) begin
        fail_count++;
        $display("[TB] FAIL midreset_after d%0d: got %h (found=%0d) want %h", d, led, ok, want_led[d]);
      end
    end
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    rst        = 1'b1;
    test_reset();
    test_scan();
    test_tick();
    test_minute_carry();
    test_rollover();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
